// File: rtl/fp_div_writeback_stage.sv
// fp_div_writeback_stage
//   Writeback stage behind the FP32 divider. Each incoming quotient has its
//   division special cases resolved: 0/0 becomes a canonical NaN and x/0
//   becomes a signed infinity. The quotient is then queued together with its
//   destination register tag. Entries drain to the FP register-file write
//   port over a valid/ready handshake. The stage also keeps the sticky
//   fflags for fcsr.
//
// Ports
//   CLK, RST              clock (rising edge), asynchronous active-high reset
//   InValid / InReady     divider handshake; InReady = (count != DEPTH)
//   Result, DZF, ZeroFlag raw quotient, divisor-zero, dividend-zero
//   InRd                  destination FP register index
//   Flush                 discards all buffered entries
//   WrValid / WrReady     register-file handshake; WrValid = (count != 0)
//   WrData, WrRd          head entry value and destination
//   FflagsWe, FflagsWData CSR write of fflags {NV,DZ,OF,UF,NX}
//   Fflags                sticky flags {NV,DZ,OF,UF,NX}
module fp_div_writeback_stage #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        InValid,
  output logic        InReady,
  input  logic [31:0] Result,
  input  logic        DZF,
  input  logic        ZeroFlag,
  input  logic [4:0]  InRd,
  input  logic        Flush,
  output logic        WrValid,
  input  logic        WrReady,
  output logic [31:0] WrData,
  output logic [4:0]  WrRd,
  input  logic        FflagsWe,
  input  logic [4:0]  FflagsWData,
  output logic [4:0]  Fflags
);

  localparam int DATA_W = 32;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // 0/0 gives the canonical NaN; x/0 gives infinity carrying the quotient sign.
  function automatic logic [DATA_W-1:0] resolve_data(input logic [DATA_W-1:0] res,
                                                     input logic dzf, input logic zf);
    if (dzf && zf)
      return CANON_NAN;
    else if (dzf)
      return {res[31], 8'hFF, 23'h0};
    else
      return res;
  endfunction

  function automatic logic [4:0] resolve_flags(input logic dzf, input logic zf);
    if (dzf && zf)
      return 5'b10000;
    else if (dzf)
      return 5'b01000;
    else
      return 5'b00000;
  endfunction

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [4:0]        mem_rd   [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] res_data_p0;
  logic [4:0]        res_flags_p0;

  assign InReady = (count != FULL_CNT);
  assign WrValid = (count != '0);
  assign push    = InValid && InReady && !Flush;
  assign pop     = WrValid && WrReady && !Flush;

  assign res_data_p0  = resolve_data(Result, DZF, ZeroFlag);
  assign res_flags_p0 = resolve_flags(DZF, ZeroFlag);

  // ---- stage boundary: resolved quotient enters storage ----
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_data[wptr] <= res_data_p0;
      mem_rd[wptr]   <= InRd;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (Flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  // Flags accumulate at push time, so a flushed entry still keeps its flags.
  // Pushes are already blocked during a flush.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      Fflags <= 5'b0;
    else
      Fflags <= (FflagsWe ? FflagsWData : Fflags) | (push ? res_flags_p0 : 5'b0);
  end

  // ---- stage boundary: head entry to register-file write port ----
  // When the queue is empty the head is forced to zero. This also makes reset
  // zero the head without resetting storage.
  assign WrData = WrValid ? mem_data[rptr] : '0;
  assign WrRd   = WrValid ? mem_rd[rptr]   : '0;

endmodule
